// File: rtl/rnd_pkg.sv
// Shared types and constants for the random-bit harvester.
package rnd_pkg;

    // Harvest sequence: two excite/settle pairs, then a lane-by-lane scan.
    typedef enum logic [2:0] {
        IDLE,
        EXCITE_A,
        SETTLE_A,
        EXCITE_B,
        SETTLE_B,
        SCAN
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/rnd_sync.sv
// Multi-flop synchronizer for the asynchronous latch-array outputs.
module rnd_sync
    import rnd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    // Shift raw lanes through the synchronizer chain.
    // NOTE: these flops have no reset on purpose: they are a pure delay line,
    // and the FSM never captures them until well after reset has flushed them.
    always_ff @(posedge clk) begin
        stages[0] <= d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stages[i] <= stages[i-1];
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/rnd_harvester.sv
// Drives the latch array freeze line, de-biases lane pairs with a von Neumann
// corrector, packs surviving bits LSB-first into bytes and flags a stuck array.
module rnd_harvester
    import rnd_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int EXCITE_CYC   = 4,
    parameter int SETTLE_CYC   = 4,
    parameter int HEALTH_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              gen_g,
    input  logic [WIDTH-1:0]  raw_in,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              health_fail
);

    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CYC_MAX = (EXCITE_CYC > SETTLE_CYC) ? EXCITE_CYC : SETTLE_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int STALE_W = $clog2(HEALTH_LIMIT + 1);
    localparam int BIT_W   = $clog2(BYTE_W);

    state_t             state, state_nxt;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   sync_raw, samp_a, samp_b;
    logic [BYTE_W-1:0]  acc;
    logic [BIT_W-1:0]   bit_cnt;
    logic [STALE_W-1:0] stale_cnt, stale_inc;

    logic gen_g_nxt, capture_a, capture_b;
    logic excite_done, settle_done, last_lane;
    logic harvest, completes, slot_free, stall, lane_step, stale_pair;

    rnd_sync #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .d   (raw_in),
        .q   (sync_raw)
    );

    assign excite_done = (cyc_cnt == CYC_W'(EXCITE_CYC - 1));
    assign settle_done = (cyc_cnt == CYC_W'(SETTLE_CYC - 1));
    assign last_lane   = (idx == IDX_W'(WIDTH - 1));

    // A lane contributes a bit only when its two samples differ. Once the
    // array is judged stuck, nothing more is harvested so no byte can form.
    assign harvest    = (state == SCAN) && (samp_a[idx] ^ samp_b[idx]) && !health_fail;
    assign completes  = harvest && (bit_cnt == BIT_W'(BYTE_W - 1));
    assign slot_free  = !byte_valid || byte_ready;
    assign stall      = completes && !slot_free;
    assign lane_step  = (state == SCAN) && !stall;

    assign stale_pair = (samp_a == sync_raw);
    assign stale_inc  = (stale_cnt == STALE_W'(HEALTH_LIMIT)) ? stale_cnt
                                                              : stale_cnt + 1'b1;

    // State register.
    // NOTE: clocked blocks use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a started pass always runs through its scan.
    // NOTE: state_nxt is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (en)          state_nxt = EXCITE_A;
            EXCITE_A: if (excite_done) state_nxt = SETTLE_A;
            SETTLE_A: if (settle_done) state_nxt = EXCITE_B;
            EXCITE_B: if (excite_done) state_nxt = SETTLE_B;
            SETTLE_B: if (settle_done) state_nxt = SCAN;
            SCAN:     if (lane_step && last_lane) state_nxt = en ? EXCITE_A : IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Output decode: freeze line level and sample-capture strobes.
    always_comb begin
        gen_g_nxt = !((state == EXCITE_A) || (state == EXCITE_B));
        capture_a = (state == SETTLE_A) && settle_done;
        capture_b = (state == SETTLE_B) && settle_done;
    end

    // Phase timer and scan lane index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            idx     <= '0;
        end else begin
            if (state_nxt != state || state == IDLE || state == SCAN) cyc_cnt <= '0;
            else                                                       cyc_cnt <= cyc_cnt + 1'b1;
            if (state != SCAN || (lane_step && last_lane)) idx <= '0;
            else if (lane_step)                             idx <= idx + 1'b1;
        end
    end

    // Registered freeze line, sample capture and stuck-array detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_g       <= 1'b1;
            samp_a      <= '0;
            samp_b      <= '0;
            stale_cnt   <= '0;
            health_fail <= 1'b0;
        end else begin
            gen_g <= gen_g_nxt;
            if (capture_a) samp_a <= sync_raw;
            if (capture_b) begin
                samp_b <= sync_raw;
                if (stale_pair) begin
                    stale_cnt <= stale_inc;
                    if (stale_inc == STALE_W'(HEALTH_LIMIT)) health_fail <= 1'b1;
                end else begin
                    stale_cnt <= '0;
                end
            end
        end
    end

    // Bit accumulator and the single-entry output byte slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
        end else begin
            if (byte_valid && byte_ready) byte_valid <= 1'b0;
            if (harvest && !stall) begin
                acc[bit_cnt] <= samp_a[idx];
                bit_cnt      <= bit_cnt + 1'b1;
            end
            if (completes && slot_free) begin
                byte_data  <= {samp_a[idx], acc[BYTE_W-2:0]};
                byte_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rnd_harvester.sv
// Scoreboard bench: a behavioural latch-array model feeds raw_in on each
// freeze edge, expected bytes are queued, and a monitor checks deliveries.
module tb_rnd_harvester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       byte_ready = 1'b1;
    logic [3:0] raw_in = 4'd0;
    logic       gen_g, byte_valid, health_fail;
    logic [7:0] byte_data;

    logic [15:0] raw16 = 16'd0;
    logic        gen16, bv16, hf16;
    logic [7:0]  bd16;

    int n_checks = 0;
    int n_pass = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int vld_cycles = 0;
    int pushed = 0;
    int popped = 0;

    logic [3:0] raw_q [$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    rnd_harvester #(.WIDTH(4), .HEALTH_LIMIT(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .gen_g(gen_g), .raw_in(raw_in),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .health_fail(health_fail)
    );

    rnd_harvester u_dut16 (
        .clk(clk), .rst(rst), .en(en), .gen_g(gen16), .raw_in(raw16),
        .byte_data(bd16), .byte_valid(bv16), .byte_ready(1'b1),
        .health_fail(hf16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Latch-array model: each freeze edge latches the next queued lane pattern.
    always @(posedge gen_g) begin
        if (rst === 1'b0) begin
            rise_cnt++;
            if (raw_q.size() > 0) raw_in = raw_q.pop_front();
        end
    end

    always @(negedge gen_g) begin
        if (rst === 1'b0) fall_cnt++;
    end

    // Monitor: every accepted byte is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (byte_valid) vld_cycles++;
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) check("byte_unexpected", 32'(popped + 1), 32'(pushed));
                else                   check("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
                popped++;
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_rises(input int n);
        int target;
        target = rise_cnt + n;
        for (int c = 0; c < 3000 && rise_cnt < target; c++) begin
            @(posedge clk);
            #1;
        end
        if (rise_cnt < target) check("rise_timeout", 32'(rise_cnt), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        raw_q.delete();
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        pushed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, f0, v0;
        logic exp_g;

        // Reset with en high: outputs idle and the freeze line stays high.
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycles(1);
            check("rst_gen_g", 32'(gen_g), 32'd1);
            check("rst_byte_valid", 32'(byte_valid), 32'd0);
            check("rst_health", 32'(health_fail), 32'd0);
            check("rst_gen16", 32'(gen16), 32'd1);
        end
        rst = 1'b0;

        // Freeze-line timing for a 16-lane pass: 0000 1111 0000 1111, 16 high, repeat.
        for (int i = 1; i <= 37; i++) begin
            cycles(1);
            exp_g = !((i >= 2 && i <= 5) || (i >= 10 && i <= 13) || (i >= 34 && i <= 37));
            check($sformatf("timing_c%0d", i), 32'(gen16), 32'(exp_g));
        end

        // Corrector: 1010/0101 twice -> 0xAA one cycle after lane 3 of pass 2.
        do_reset();
        byte_ready = 1'b1;
        raw_q = {4'b1010, 4'b0101, 4'b1010, 4'b0101};
        expect_byte(8'hAA);
        en = 1'b1;
        wait_rises(3);
        en = 1'b0;
        wait_rises(1);
        cycles(6);
        check("corr_valid_early", 32'(byte_valid), 32'd0);
        cycles(1);
        check("corr_valid", 32'(byte_valid), 32'd1);
        check("corr_data", 32'(byte_data), 32'hAA);
        cycles(4);
        check("corr_drain", 32'(exp_q.size()), 32'd0);

        // Partial differences: one '1' bit per pass, eight passes -> 0xFF.
        do_reset();
        for (int p = 0; p < 8; p++) begin
            raw_q.push_back(4'b0011);
            raw_q.push_back(4'b0001);
        end
        expect_byte(8'hFF);
        en = 1'b1;
        wait_rises(15);
        en = 1'b0;
        wait_rises(1);
        cycles(10);
        check("partial_drain", 32'(exp_q.size()), 32'd0);
        check("partial_idle_gen_g", 32'(gen_g), 32'd1);

        // Backpressure: second byte completes while the first is still held.
        do_reset();
        byte_ready = 1'b0;
        raw_q = {4'b1010, 4'b0101, 4'b1010, 4'b0101,
                 4'b1111, 4'b0000, 4'b1111, 4'b0000};
        expect_byte(8'hAA);
        expect_byte(8'hFF);
        en = 1'b1;
        wait_rises(8);
        f0 = fall_cnt;
        cycles(30);
        check("bp_stalled", 32'(fall_cnt - f0), 32'd0);
        check("bp_hold_valid", 32'(byte_valid), 32'd1);
        check("bp_hold_data", 32'(byte_data), 32'hAA);
        en = 1'b0;
        byte_ready = 1'b1;
        cycles(1);
        check("bp_second_valid", 32'(byte_valid), 32'd1);
        check("bp_second_data", 32'(byte_data), 32'hFF);
        cycles(20);
        check("bp_no_new_pass", 32'(fall_cnt - f0), 32'd0);
        check("bp_idle_gen_g", 32'(gen_g), 32'd1);
        check("bp_drain", 32'(exp_q.size()), 32'd0);

        // Health: constant 0110 flags a stuck array on the 4th scan entry.
        do_reset();
        byte_ready = 1'b1;
        for (int p = 0; p < 12; p++) raw_q.push_back(4'b0110);
        v0 = vld_cycles;
        en = 1'b1;
        wait_rises(8);
        cycles(2);
        check("health_before", 32'(health_fail), 32'd0);
        cycles(1);
        check("health_set", 32'(health_fail), 32'd1);
        wait_rises(1);
        cycles(5);
        check("health_in_excite_b", 32'(gen_g), 32'd0);
        en = 1'b0;
        r0 = rise_cnt;
        f0 = fall_cnt;
        cycles(30);
        check("health_pass_done", 32'(rise_cnt - r0), 32'd1);
        check("health_no_restart", 32'(fall_cnt - f0), 32'd0);
        check("health_idle_gen_g", 32'(gen_g), 32'd1);
        check("health_sticky", 32'(health_fail), 32'd1);
        check("health_no_bytes", 32'(vld_cycles - v0), 32'd0);
        do_reset();
        check("health_cleared", 32'(health_fail), 32'd0);
        check("health_rst_gen_g", 32'(gen_g), 32'd1);

        check("bytes_delivered", 32'(popped), 32'(pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
